// File: rtl/sa_operand_streamer.sv
// sa_operand_streamer: preloaded operand-pair table streamed as full-width
// AA/BB beats over a valid/ready handshake, in one-shot or loop mode.
// Each beat fetches LANES entries (one per cycle) into shadow lanes, then
// presents them together. One-shot streams zero-pad the final beat.
// Optional build macro SA_STREAM_SIG_EN adds a 32-bit rolling signature
// output `sig` over all accepted beats.
module sa_operand_streamer #(
   parameter int WIDTH  = 8,
   parameter int HPE    = 4,
   parameter int VPE    = 4,
   parameter int DEPTH  = 10000,
   parameter int ADDR_W = 14
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [2*WIDTH-1:0]   wr_data,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 mode_loop,
   input  logic [ADDR_W:0]      len,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH*HPE-1:0] AA,
   output logic [WIDTH*VPE-1:0] BB,
   output logic                 busy,
   output logic                 done,
`ifdef SA_STREAM_SIG_EN
   output logic [31:0]          sig,
`endif
   output logic [31:0]          beat_cnt
);

   localparam int LANES = (HPE > VPE) ? HPE : VPE;
   localparam int W2    = 2 * WIDTH;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW    = $clog2(LANES + 1);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_PRESENT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [W2-1:0]       mem [DEPTH];
   logic [W2-1:0]       rd_q;
   logic                pad_q;
   logic [W2-1:0]       cap;
   logic [W2-1:0]       sh_q [LANES];
   logic [W2-1:0]       sh_d [LANES];
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [FW-1:0]       fcnt_q, fcnt_d;
   logic                exh_q, exh_d;
   logic                stop_q, stop_d;
   logic                loop_q, loop_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [WIDTH*HPE-1:0] aa_q, aa_d;
   logic [WIDTH*VPE-1:0] bb_q, bb_d;
   logic [31:0]         cnt_q, cnt_d;
`ifdef SA_STREAM_SIG_EN
   logic [31:0]         sig_q, sig_d;
   logic [31:0]         fold;
`endif

   // Table write port: host writes land only while idle and in range
   always_ff @(posedge CLK) begin
      if (wr_en && !busy && ({1'b0, wr_addr} < DEPTH_L))
         mem[wr_addr[IW-1:0]] <= wr_data;
   end

   // Synchronous table read and shadow-lane storage (data only, no reset)
   always_ff @(posedge CLK) begin
      rd_q <= mem[ptr_q[IW-1:0]];
      sh_q <= sh_d;
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state: fill LANES entries, present, then loop, stop or finish
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start && (len != '0)) state_d = S_FILL;
         S_FILL:    if (fcnt_q == FW'(LANES)) state_d = S_PRESENT;
         S_PRESENT: begin
            if (out_ready) begin
               if (!loop_q && exh_q)   state_d = S_DONE;
               else if (stop_q || stop) state_d = S_IDLE;
               else                    state_d = S_FILL;
            end
         end
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      out_valid = (state_q == S_PRESENT);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
   end

   // Datapath next-state: pointer walk, lane capture, beat assembly, counters
   always_comb begin
      ptr_d  = ptr_q;
      fcnt_d = fcnt_q;
      exh_d  = exh_q;
      loop_d = loop_q;
      len_d  = len_q;
      aa_d   = aa_q;
      bb_d   = bb_q;
      cnt_d  = cnt_q;
      sh_d   = sh_q;
      cap    = pad_q ? '0 : rd_q;
`ifdef SA_STREAM_SIG_EN
      sig_d  = sig_q;
      fold   = '0;
      for (int n = 0; n < HPE; n++) fold = fold ^ 32'(aa_q[n*WIDTH +: WIDTH]);
      for (int n = 0; n < VPE; n++) fold = fold ^ 32'(bb_q[n*WIDTH +: WIDTH]);
`endif
      case (state_q)
         S_IDLE: begin
            if (start && (len != '0)) begin
               ptr_d  = '0;
               fcnt_d = '0;
               exh_d  = 1'b0;
               cnt_d  = '0;
               loop_d = mode_loop;
               len_d  = (len > DEPTH_L) ? DEPTH_L : len;
`ifdef SA_STREAM_SIG_EN
               sig_d  = '0;
`endif
            end
         end
         S_FILL: begin
            // Read data for lane (fcnt-1) arrives one cycle after its fetch
            for (int n = 0; n < LANES; n++)
               if (fcnt_q == FW'(n + 1)) sh_d[n] = cap;
            if (fcnt_q == FW'(LANES)) begin
               fcnt_d = '0;
               for (int n = 0; n < HPE; n++) aa_d[n*WIDTH +: WIDTH] = sh_d[n][W2-1:WIDTH];
               for (int n = 0; n < VPE; n++) bb_d[n*WIDTH +: WIDTH] = sh_d[n][WIDTH-1:0];
            end else begin
               fcnt_d = fcnt_q + 1'b1;
               // Once a one-shot stream is exhausted the pointer parks and
               // the remaining fetches of the beat are zero-padded
               if (!exh_q) begin
                  if ({1'b0, ptr_q} == (len_q - 1'b1)) begin
                     if (loop_q) ptr_d = '0;
                     else        exh_d = 1'b1;
                  end else begin
                     ptr_d = ptr_q + 1'b1;
                  end
               end
            end
         end
         S_PRESENT: begin
            if (out_ready) begin
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`ifdef SA_STREAM_SIG_EN
               sig_d = {sig_q[30:0], sig_q[31]} ^ fold;
`endif
            end
         end
         default: ;
      endcase
      // Stop request is remembered until the stream returns to idle
      if (state_d == S_IDLE)                   stop_d = 1'b0;
      else if (stop && (state_q != S_IDLE))    stop_d = 1'b1;
      else                                     stop_d = stop_q;
   end

   // Datapath control registers and output holding registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q  <= '0;
         fcnt_q <= '0;
         exh_q  <= 1'b0;
         pad_q  <= 1'b0;
         stop_q <= 1'b0;
         loop_q <= 1'b0;
         len_q  <= '0;
         aa_q   <= '0;
         bb_q   <= '0;
         cnt_q  <= '0;
`ifdef SA_STREAM_SIG_EN
         sig_q  <= '0;
`endif
      end else begin
         ptr_q  <= ptr_d;
         fcnt_q <= fcnt_d;
         exh_q  <= exh_d;
         pad_q  <= exh_q;
         stop_q <= stop_d;
         loop_q <= loop_d;
         len_q  <= len_d;
         aa_q   <= aa_d;
         bb_q   <= bb_d;
         cnt_q  <= cnt_d;
`ifdef SA_STREAM_SIG_EN
         sig_q  <= sig_d;
`endif
      end
   end

   assign AA       = aa_q;
   assign BB       = bb_q;
   assign beat_cnt = cnt_q;
`ifdef SA_STREAM_SIG_EN
   assign sig      = sig_q;
`endif

endmodule

// File: tb/tb_sa_operand_streamer.sv
// Testbench for sa_operand_streamer: directed scenarios plus randomized
// one-shot streams with random back-pressure, checked against a table model.
`timescale 1ns/1ps
module tb_sa_operand_streamer;
   localparam int WIDTH = 8, HPE = 4, VPE = 4, DEPTH = 16, ADDR_W = 5, LANES = 4;

   logic               CLK = 1'b0;
   logic               RST, wr_en, start, stop, mode_loop, out_ready;
   logic [ADDR_W-1:0]  wr_addr;
   logic [15:0]        wr_data;
   logic [ADDR_W:0]    len;
   logic               out_valid, busy, done;
   logic [31:0]        AA, BB, beat_cnt;
`ifdef SA_STREAM_SIG_EN
   logic [31:0]        sig;
`endif

   int n_chk = 0;
   int n_pass = 0;
   logic [15:0] mem_m [DEPTH];

   always #5 CLK = ~CLK;

   sa_operand_streamer #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .mode_loop(mode_loop), .len(len),
      .out_valid(out_valid), .out_ready(out_ready), .AA(AA), .BB(BB),
      .busy(busy), .done(done),
`ifdef SA_STREAM_SIG_EN
      .sig(sig),
`endif
      .beat_cnt(beat_cnt));

   // Expected beat k of a stream: lane n takes table entry k*LANES+n,
   // wrapped modulo the clamped length in loop mode, zero past the end otherwise
   function automatic logic [63:0] model_beat(input int k, input int l, input bit lp);
      int eff;
      int idx;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] e;
      eff = (l > DEPTH) ? DEPTH : l;
      a = '0;
      b = '0;
      for (int n = 0; n < LANES; n++) begin
         idx = k * LANES + n;
         e = 16'h0;
         if (lp) e = mem_m[idx % eff];
         else if (idx < eff) e = mem_m[idx];
         a[n*8 +: 8] = e[15:8];
         b[n*8 +: 8] = e[7:0];
      end
      return {a, b};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_start(input int l, input bit lp, input bit stp);
      start = 1'b1; len = 6'(l); mode_loop = lp; stop = stp;
      tick();
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic wait_valid(output int n, output bit ok);
      n = 0; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(); n++;
         if (out_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic drain(output int dn, output bit ok);
      dn = 0; ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (done) dn++;
         if (!busy) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic load_table();
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i);
         wr_data = {8'(i + 1), 8'(8'h80 + i)};
         mem_m[i] = wr_data;
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) tick();
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else n_pass++;
      n_chk++; if ({AA, BB} !== 64'h0) $display("FAIL rst_aabb got %h want 0", {AA, BB}); else n_pass++;
      n_chk++; if ({busy, done} !== 2'b00) $display("FAIL rst_busy_done got %b want 00", {busy, done}); else n_pass++;
      n_chk++; if (beat_cnt !== 32'h0) $display("FAIL rst_cnt got %0d want 0", beat_cnt); else n_pass++;
      RST = 1'b0;
      tick();
      load_table();
      do_start(0, 1'b0, 1'b0);
      n_chk++; if (busy !== 1'b0) $display("FAIL len0_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_oneshot();
      int n, dn; bit ok, okd;
      out_ready = 1'b1;
      do_start(8, 1'b0, 1'b0);
      wait_valid(n, ok);
      n_chk++; if (!ok || n != 5) $display("FAIL os_lat1 got %0d want 5 cycles", n); else n_pass++;
      n_chk++; if (AA !== 32'h04030201) $display("FAIL os_aa1 got %h want 04030201", AA); else n_pass++;
      n_chk++; if (BB !== 32'h83828180) $display("FAIL os_bb1 got %h want 83828180", BB); else n_pass++;
      wait_valid(n, ok);
      n_chk++; if (!ok || n != LANES + 2) $display("FAIL os_lat2 got %0d want %0d cycles", n, LANES + 2); else n_pass++;
      n_chk++; if (AA !== 32'h08070605) $display("FAIL os_aa2 got %h want 08070605", AA); else n_pass++;
      n_chk++; if (BB !== 32'h87868584) $display("FAIL os_bb2 got %h want 87868584", BB); else n_pass++;
      drain(dn, okd);
      n_chk++; if (!okd || dn != 1) $display("FAIL os_done got %0d pulses want 1", dn); else n_pass++;
      n_chk++; if (beat_cnt !== 32'd2) $display("FAIL os_cnt got %0d want 2", beat_cnt); else n_pass++;
      tick();
      n_chk++; if ({busy, done} !== 2'b00) $display("FAIL os_idle got %b want 00", {busy, done}); else n_pass++;
   endtask

   task automatic test_zero_pad();
      int n, dn; bit ok, okd;
      out_ready = 1'b1;
      do_start(6, 1'b0, 1'b0);
      wait_valid(n, ok);
      n_chk++; if (!ok || AA !== 32'h04030201) $display("FAIL pad_aa1 got %h want 04030201", AA); else n_pass++;
      wait_valid(n, ok);
      n_chk++; if (!ok || AA !== 32'h00000605) $display("FAIL pad_aa2 got %h want 00000605", AA); else n_pass++;
      n_chk++; if (BB !== 32'h00008584) $display("FAIL pad_bb2 got %h want 00008584", BB); else n_pass++;
      drain(dn, okd);
      n_chk++; if (!okd || dn != 1) $display("FAIL pad_done got %0d pulses want 1", dn); else n_pass++;
      n_chk++; if (beat_cnt !== 32'd2) $display("FAIL pad_cnt got %0d want 2", beat_cnt); else n_pass++;
   endtask

   task automatic test_loop_stop();
      int n, dn; bit ok, okd;
      logic [63:0] exp;
      logic [31:0] aa_exp [4];
      aa_exp[0] = 32'h04030201; aa_exp[1] = 32'h02010605;
      aa_exp[2] = 32'h06050403; aa_exp[3] = 32'h04030201;
      out_ready = 1'b1;
      // stop together with start is discarded: the loop must keep running
      do_start(6, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            tick(); tick();
            stop = 1'b1; tick(); stop = 1'b0;
         end
         wait_valid(n, ok);
         exp = model_beat(k, 6, 1'b1);
         n_chk++; if (!ok || AA !== aa_exp[k]) $display("FAIL loop_aa%0d got %h want %h", k, AA, aa_exp[k]); else n_pass++;
         n_chk++; if (BB !== exp[31:0]) $display("FAIL loop_bb%0d got %h want %h", k, BB, exp[31:0]); else n_pass++;
      end
      drain(dn, okd);
      n_chk++; if (!okd || dn != 0) $display("FAIL loop_nodone got %0d pulses want 0 (ended %b)", dn, okd); else n_pass++;
      n_chk++; if (beat_cnt !== 32'd4) $display("FAIL loop_cnt got %0d want 4", beat_cnt); else n_pass++;
   endtask

   task automatic test_backpressure();
      int n, dn; bit ok, okd;
      out_ready = 1'b0;
      do_start(8, 1'b0, 1'b0);
      wait_valid(n, ok);
      n_chk++; if (!ok || AA !== 32'h04030201) $display("FAIL bp_aa got %h want 04030201", AA); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_chk++; if (out_valid !== 1'b1 || AA !== 32'h04030201 || BB !== 32'h83828180)
            $display("FAIL bp_hold%0d got v=%b %h/%h want 1 04030201/83828180", i, out_valid, AA, BB); else n_pass++;
         n_chk++; if (beat_cnt !== 32'd0) $display("FAIL bp_cnt%0d got %0d want 0", i, beat_cnt); else n_pass++;
      end
      out_ready = 1'b1;
      tick();
      n_chk++; if (out_valid !== 1'b0 || beat_cnt !== 32'd1) $display("FAIL bp_adv got v=%b cnt=%0d want 0/1", out_valid, beat_cnt); else n_pass++;
      n_chk++; if (AA !== 32'h04030201) $display("FAIL bp_keep got %h want 04030201", AA); else n_pass++;
      wait_valid(n, ok);
      n_chk++; if (!ok || AA !== 32'h08070605) $display("FAIL bp_aa2 got %h want 08070605", AA); else n_pass++;
      drain(dn, okd);
      n_chk++; if (!okd || dn != 1 || beat_cnt !== 32'd2) $display("FAIL bp_end got done=%0d cnt=%0d want 1/2", dn, beat_cnt); else n_pass++;
   endtask

   task automatic test_rst_mid();
      int n, dn; bit ok, okd;
      out_ready = 1'b1;
      do_start(8, 1'b0, 1'b0);
      tick();
      RST = 1'b1;
      tick();
      n_chk++; if ({out_valid, busy, done} !== 3'b000) $display("FAIL mid_ctl got %b want 000", {out_valid, busy, done}); else n_pass++;
      n_chk++; if ({AA, BB} !== 64'h0 || beat_cnt !== 32'h0) $display("FAIL mid_data got %h cnt=%0d want 0", {AA, BB}, beat_cnt); else n_pass++;
      RST = 1'b0;
      tick();
      do_start(8, 1'b0, 1'b0);
      wait_valid(n, ok);
      n_chk++; if (!ok || n != 5 || {AA, BB} !== 64'h04030201_83828180) $display("FAIL mid_re1 got %h lat=%0d want 0403020183828180 lat=5", {AA, BB}, n); else n_pass++;
      wait_valid(n, ok);
      n_chk++; if (!ok || {AA, BB} !== 64'h08070605_87868584) $display("FAIL mid_re2 got %h want 0807060587868584", {AA, BB}); else n_pass++;
      drain(dn, okd);
      n_chk++; if (!okd || dn != 1 || beat_cnt !== 32'd2) $display("FAIL mid_end got done=%0d cnt=%0d want 1/2", dn, beat_cnt); else n_pass++;
   endtask

   task automatic test_write_rules();
      int n, dn; bit ok, okd;
      logic [63:0] exp;
      out_ready = 1'b1;
      // Out-of-range address must not alias onto a real entry
      wr_en = 1'b1; wr_addr = 5'd20; wr_data = 16'hDEAD; tick(); wr_en = 1'b0;
      do_start(8, 1'b0, 1'b0);
      // Write while busy must be dropped
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'hBEEF; tick(); wr_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wait_valid(n, ok);
         exp = model_beat(k, 8, 1'b0);
         n_chk++; if (!ok || {AA, BB} !== exp) $display("FAIL wr_beat%0d got %h want %h", k, {AA, BB}, exp); else n_pass++;
      end
      drain(dn, okd);
      do_start(4, 1'b0, 1'b0);
      wait_valid(n, ok);
      n_chk++; if (!ok || {AA, BB} !== 64'h04030201_83828180) $display("FAIL wr_busy got %h want 0403020183828180", {AA, BB}); else n_pass++;
      drain(dn, okd);
      n_chk++; if (!okd || dn != 1 || beat_cnt !== 32'd1) $display("FAIL wr_end got done=%0d cnt=%0d want 1/1", dn, beat_cnt); else n_pass++;
   endtask

   task automatic test_clamp();
      int n, dn; bit ok, okd;
      logic [63:0] exp;
      out_ready = 1'b1;
      do_start(40, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         wait_valid(n, ok);
         exp = model_beat(k, 40, 1'b0);
         n_chk++; if (!ok || {AA, BB} !== exp) $display("FAIL clamp_beat%0d got %h want %h", k, {AA, BB}, exp); else n_pass++;
      end
      n_chk++; if ({AA, BB} !== 64'h100F0E0D_8F8E8D8C) $display("FAIL clamp_last got %h want 100F0E0D8F8E8D8C", {AA, BB}); else n_pass++;
      drain(dn, okd);
      n_chk++; if (!okd || dn != 1 || beat_cnt !== 32'd4) $display("FAIL clamp_end got done=%0d cnt=%0d want 1/4", dn, beat_cnt); else n_pass++;
   endtask

   task automatic test_random();
      int l, eff, nb, k, dn;
      bit fin;
      logic [63:0] exp;
`ifdef SA_STREAM_SIG_EN
      logic [31:0] sig_m;
      logic [31:0] f;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = 16'($urandom);
         mem_m[i] = wr_data;
         tick();
      end
      wr_en = 1'b0;
      for (int t = 0; t < 8; t++) begin
         l = $urandom_range(1, 20);
         eff = (l > DEPTH) ? DEPTH : l;
         nb = (eff + LANES - 1) / LANES;
         k = 0; dn = 0; fin = 1'b0;
`ifdef SA_STREAM_SIG_EN
         sig_m = '0;
`endif
         out_ready = 1'b0;
         do_start(l, 1'b0, 1'b0);
         for (int c = 0; c < 400; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (done) dn++;
            if (!busy) begin fin = 1'b1; break; end
            if (out_valid) begin
               exp = model_beat(k, l, 1'b0);
               n_chk++; if ({AA, BB} !== exp) $display("FAIL rnd%0d_beat%0d got %h want %h", t, k, {AA, BB}, exp); else n_pass++;
               if (out_ready) begin
`ifdef SA_STREAM_SIG_EN
                  f = '0;
                  for (int b = 0; b < 8; b++) f = f ^ 32'(exp[b*8 +: 8]);
                  sig_m = {sig_m[30:0], sig_m[31]} ^ f;
`endif
                  k++;
               end
            end
            tick();
         end
         n_chk++; if (!fin || k != nb) $display("FAIL rnd%0d_beats got %0d want %0d (ended %b)", t, k, nb, fin); else n_pass++;
         n_chk++; if (dn != 1) $display("FAIL rnd%0d_done got %0d want 1", t, dn); else n_pass++;
         n_chk++; if (beat_cnt !== 32'(nb)) $display("FAIL rnd%0d_cnt got %0d want %0d", t, beat_cnt, nb); else n_pass++;
`ifdef SA_STREAM_SIG_EN
         n_chk++; if (sig !== sig_m) $display("FAIL rnd%0d_sig got %h want %h", t, sig, sig_m); else n_pass++;
`endif
      end
   endtask

   initial begin
      RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; stop = 1'b0; mode_loop = 1'b0; len = '0; out_ready = 1'b1;
      test_reset();
      test_oneshot();
      test_zero_pad();
      test_loop_stop();
      test_backpressure();
      test_rst_mid();
      test_write_rules();
      test_clamp();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sa_operand_streamer.md
Name: sa_operand_streamer

Overview:
Synthesizable operand source for the systolic-array DUTs.
- Holds a preloaded table of packed operand pairs. Each entry is 2*WIDTH bits: A in the upper half, B in the lower half.
- Streams the table as full-width AA/BB beats through a valid/ready handshake.
- Generalised in lane counts (HPE, VPE), table depth, stream length and mode: one-shot or loop.
- Sits between the host/load path and the array's AA/BB inputs.

Parameters:
WIDTH, 8, bits per operand lane
HPE, 4, number of A lanes (AA width WIDTH*HPE)
VPE, 4, number of B lanes (BB width WIDTH*VPE)
DEPTH, 10000, table entries
ADDR_W, 14, table address width; 2**ADDR_W >= DEPTH
LANES, max(HPE,VPE), derived: entries consumed per beat

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
wr_en  in  1  table write strobe; ignored while busy
wr_addr  in  ADDR_W  table write address; writes with addr >= DEPTH are ignored
wr_data  in  2*WIDTH  table entry: [2W-1:W]=A, [W-1:0]=B
start  in  1  begin stream; ignored while busy or when len==0
stop  in  1  request end of loop stream at the next beat boundary
mode_loop  in  1  sampled at start: 1=wrap forever, 0=one-shot
len  in  ADDR_W+1  entries in stream, sampled at start; values > DEPTH clamp to DEPTH
out_valid  out  1  AA/BB beat valid
out_ready  in  1  consumer accepts beat
AA  out  WIDTH*HPE  A lanes; lane n at [(n+1)*WIDTH-1 : n*WIDTH]
BB  out  WIDTH*VPE  B lanes, same packing
busy  out  1  high from the cycle after start until return to IDLE
done  out  1  one-cycle pulse at one-shot completion
beat_cnt  out  32  handshaken beats since last start; saturates at 2^32-1

Behaviour:
- Reset: all outputs 0; FSM=IDLE; read pointer 0; stop latch cleared. Table contents are not reset.
- Table read port is synchronous with 1-cycle latency. Writes take effect on the next cycle.
- FSM has states IDLE, FILL, PRESENT, DONE.
- IDLE:
  - start with len!=0 → FILL.
  - Pointer is set to 0, beat_cnt is cleared, and mode_loop/len are latched.
- FILL:
  - Fetches one entry per cycle for lanes 0..LANES-1 in order.
  - Lane n receives the entry at pointer p0+n, wrapping as defined below.
  - A half goes to AA lane n if n<HPE; B half goes to BB lane n if n<VPE.
  - Shadow lanes are loaded LANES+1 cycles after entering FILL; AA/BB and out_valid update together, then → PRESENT.
- Pointer wrap: pointer == len-1 after a fetch:
  - Loop mode: next pointer is 0.
  - One-shot mode: the stream is exhausted; remaining lanes of that beat load 0 (zero pad).
- PRESENT:
  - out_valid=1. AA/BB are held stable until out_valid&&out_ready.
  - On handshake, beat_cnt+1, then:
    - one-shot and exhausted → DONE;
    - else stop latched → IDLE, no done pulse;
    - else → FILL.
  - out_valid drops in the cycle after the handshake. AA/BB keep their last value.
- DONE: done=1 for exactly one cycle → IDLE.
- stop: latched in any non-IDLE state and cleared on entry to IDLE. It is honoured only at a beat boundary; a partial beat is never dropped. stop in one-shot mode ends the stream early, with no done pulse.
- Simultaneous events:
  - start and stop in the same IDLE cycle: start wins and stop is discarded.
  - wr_en during busy: dropped.
- RST mid-operation: abort, outputs to reset values, no done pulse. A subsequent start replays from entry 0.
- Throughput: one beat per LANES+2 cycles with out_ready tied high.

Optional Feature:
SA_STREAM_SIG_EN
- Defined:
  - Adds output sig[31:0], reset to 0 and cleared on accepted start.
  - On every handshake: sig <= {sig[30:0],sig[31]} ^ F.
  - F is the XOR of all HPE AA lanes and all VPE BB lanes, each zero-extended to 32 bits.
  - Used for golden-run comparison against the array output.
- Undefined: sig port and logic absent; all other behaviour identical.

Test Plan:
Common setup: WIDTH=8, HPE=VPE=4, DEPTH=16, out_ready=1 unless stated; table loaded mem[i]={i+1, 8'h80+i}, i=0..15.
1. One-shot, len=8, start → two beats:
   - AA=32'h04030201, BB=32'h83828180;
   - then AA=32'h08070605, BB=32'h87868584;
   - one done pulse; beat_cnt=2; busy low afterwards.
2. One-shot, len=6 → second beat AA=32'h00000605, BB=32'h00008584 (zero pad); done pulses once.
3. Loop, len=6:
   - beats AA=32'h04030201, then 32'h02010605, then 32'h06050403;
   - stop asserted mid-FILL of beat 4 → beat 4 still presented, then IDLE, no done, beat_cnt=4.
4. out_ready low for 5 cycles during PRESENT → out_valid stays 1, AA/BB unchanged, beat_cnt unchanged; advance only on the cycle out_ready=1.
5. RST asserted 2 cycles into FILL → next cycle all outputs 0 and busy=0; a restart with len=8 reproduces scenario 1 exactly (table retained). wr_en during busy → table unchanged.
